// File: rtl/fd_fetch_buffer_pkg.sv
// Shared types and constants for the fetch/decode buffer: entry layout,
// default bubble instruction and occupancy type.
package fd_fetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] occ_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            adel;
        logic [XLEN-1:0] badvaddr;
    } fd_entry_t;

    localparam int ENTRY_W = $bits(fd_entry_t);

    function automatic fd_entry_t reset_entry(input logic [XLEN-1:0] nop);
        fd_entry_t e;
        e.pc       = '0;
        e.instr    = nop;
        e.adel     = 1'b0;
        e.badvaddr = '0;
        return e;
    endfunction

endpackage

// File: rtl/fd_fetch_buffer_fifo2.sv
// Two-entry register FIFO; slot 0 is always the head so its register feeds
// the decode outputs directly.
module fd_fifo2
    import fd_fetch_buffer_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      clear_i,
    input  logic      push_i,
    input  fd_entry_t push_entry_i,
    input  logic      pop_i,
    output fd_entry_t head_o,
    output occ_t      occ_o
);

    fd_entry_t slot0_q, slot0_d;
    fd_entry_t slot1_q, slot1_d;
    occ_t      occ_q, occ_d;
    logic      do_pop;
    logic      do_push;

    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        if (clear_i) begin
            occ_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        slot0_d = push_entry_i;
                    end else begin
                        slot1_d = push_entry_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    occ_d   = occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, queue shifts.
                    if (occ_q == 2'd1) begin
                        slot0_d = push_entry_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot0_q <= reset_entry(NOP_INSTR);
            slot1_q <= reset_entry(NOP_INSTR);
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

    assign head_o = slot0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fd_fetch_buffer.sv
// Fetch-to-decode buffer: tracks one in-flight SRAM read, pairs it with the
// returning data a cycle later and queues the result for decode.
module fd_fetch_buffer
    import fd_fetch_buffer_pkg::*;
#(
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [XLEN-1:0] f_pc,
    input  logic            f_adel,
    input  logic [XLEN-1:0] f_badvaddr,
    input  logic [XLEN-1:0] inst_sram_rdata,
    input  logic            flush,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] d_instr,
    output logic [XLEN-1:0] d_badvaddr,
    output logic            d_adel
);

    localparam logic [2:0] CAP = 3'(DEPTH);

    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            if_adel_q, if_adel_d;
    logic [XLEN-1:0] if_badv_q, if_badv_d;

    occ_t      occ;
    fd_entry_t head;
    fd_entry_t push_entry;
    logic      accept;
    logic      pop;
    logic      push;

    assign d_valid = (occ != 2'd0);
    assign pop     = d_valid && d_ready && !flush;
    assign push    = inflight_q && !flush;

    // A pop this cycle frees the slot the next completion will need.
    assign f_ready = flush || (({1'b0, occ} + {2'b00, inflight_q}) < CAP) || (d_valid && d_ready);
    assign accept  = f_valid && f_ready;

    always_comb begin
        inflight_d = accept;
        if_pc_d    = if_pc_q;
        if_adel_d  = if_adel_q;
        if_badv_d  = if_badv_q;
        if (accept) begin
            if_pc_d   = f_pc;
            if_adel_d = f_adel;
            if_badv_d = f_adel ? f_badvaddr : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
            if_pc_q    <= '0;
            if_adel_q  <= 1'b0;
            if_badv_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            if_pc_q    <= if_pc_d;
            if_adel_q  <= if_adel_d;
            if_badv_q  <= if_badv_d;
        end
    end

    always_comb begin
        push_entry.pc       = if_pc_q;
        push_entry.instr    = if_adel_q ? NOP_INSTR : inst_sram_rdata;
        push_entry.adel     = if_adel_q;
        push_entry.badvaddr = if_badv_q;
    end

    fd_fifo2 #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .clear_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .occ_o        (occ)
    );

    assign d_pc       = head.pc;
    assign d_instr    = head.instr;
    assign d_adel     = head.adel;
    assign d_badvaddr = head.badvaddr;

endmodule

// File: tb/tb_fd_fetch_buffer.sv
// Bench for fd_fetch_buffer: per-cycle vector table for handshake flags,
// expected-entry queue for the data that reaches decode.
module tb_fd_fetch_buffer;
  import fd_fetch_buffer_pkg::*;

  localparam logic [31:0] NOP = 32'hffff_0013;

  typedef struct {
    bit          fv;
    logic [31:0] pc;
    bit          adel;
    logic [31:0] badv;
    bit          dr;
    bit          fl;
    bit          exp_fr;
    bit          exp_dv;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        f_valid, f_ready, f_adel, flush, d_valid, d_ready, d_adel;
  logic [31:0] f_pc, f_badvaddr, inst_sram_rdata, d_pc, d_instr, d_badvaddr;

  logic [ENTRY_W-1:0] exp_q[$];
  vec_t               vt[$];
  int                 n_vec = 0;
  int                 n_miss = 0;
  bit                 prev_acc = 1'b0;
  logic [31:0]        prev_pc = '0;

  fd_fetch_buffer #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .f_valid         (f_valid),
    .f_ready         (f_ready),
    .f_pc            (f_pc),
    .f_adel          (f_adel),
    .f_badvaddr      (f_badvaddr),
    .inst_sram_rdata (inst_sram_rdata),
    .flush           (flush),
    .d_valid         (d_valid),
    .d_ready         (d_ready),
    .d_pc            (d_pc),
    .d_instr         (d_instr),
    .d_badvaddr      (d_badvaddr),
    .d_adel          (d_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] pc);
    if (pc == 32'hbfc0_0000) return 32'h2408_0001;
    return pc ^ 32'h2408_1234;
  endfunction

  function automatic vec_t mk(bit fv, logic [31:0] pc, bit adel, logic [31:0] badv,
                              bit dr, bit fl, bit efr, bit edv);
    vec_t v;
    v.fv = fv; v.pc = pc; v.adel = adel; v.badv = badv;
    v.dr = dr; v.fl = fl; v.exp_fr = efr; v.exp_dv = edv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    fd_entry_t e;
    bit acc;
    @(negedge clk);
    f_valid = v.fv;
    f_pc = v.pc;
    f_adel = v.adel;
    f_badvaddr = v.badv;
    d_ready = v.dr;
    flush = v.fl;
    inst_sram_rdata = prev_acc ? sram_word(prev_pc) : $urandom;
    #1;
    chk("f_ready", {31'b0, f_ready}, {31'b0, v.exp_fr});
    chk("d_valid", {31'b0, d_valid}, {31'b0, v.exp_dv});
    if (v.exp_dv) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q[0];
        chk("d_pc", d_pc, e.pc);
        chk("d_instr", d_instr, e.instr);
        chk("d_adel", {31'b0, d_adel}, {31'b0, e.adel});
        chk("d_badvaddr", d_badvaddr, e.badvaddr);
      end
    end
    if (v.fl) exp_q.delete();
    else if (v.exp_dv && v.dr && exp_q.size() > 0) void'(exp_q.pop_front());
    acc = v.fv && v.exp_fr;
    if (acc) begin
      e.pc = v.pc;
      e.adel = v.adel;
      e.instr = v.adel ? NOP : sram_word(v.pc);
      e.badvaddr = v.adel ? v.badv : 32'h0;
      exp_q.push_back(e);
    end
    prev_acc = acc;
    prev_pc = v.pc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_f_ready"}, {31'b0, f_ready}, 32'd1);
    chk({tag, "_d_valid"}, {31'b0, d_valid}, 32'd0);
    chk({tag, "_d_pc"}, d_pc, 32'h0);
    chk({tag, "_d_instr"}, d_instr, NOP);
    chk({tag, "_d_adel"}, {31'b0, d_adel}, 32'd0);
    chk({tag, "_d_badvaddr"}, d_badvaddr, 32'h0);
  endtask

  // clock/reset
  initial begin
    resetn = 1'b1;
    f_valid = 0; f_pc = 0; f_adel = 0; f_badvaddr = 0;
    inst_sram_rdata = 0; flush = 0; d_ready = 0;
    #2 resetn = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // single fetch, two-cycle latency
    vt.push_back(mk(1, 32'hbfc0_0000, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    // stream with decode stalled, then drain
    vt.push_back(mk(1, 32'hbfc0_0000, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'hbfc0_0004, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'hbfc0_0008, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'hbfc0_0008, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'hbfc0_0008, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(1, 32'hbfc0_000c, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    // address error entry
    vt.push_back(mk(1, 32'hbfc0_0002, 1, 32'hbfc0_0002, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    // push/pop at occupancy 1 with toggling d_ready; badvaddr masked when no fault
    vt.push_back(mk(1, 32'h0000_0100, 0, 32'hdead_beef, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h0000_0104, 0, 32'hdead_beef, 0, 0, 1, 0));
    vt.push_back(mk(1, 32'h0000_0108, 0, 32'hdead_beef, 1, 0, 1, 1));
    vt.push_back(mk(1, 32'h0000_010c, 0, 32'hdead_beef, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'h0000_010c, 0, 32'hdead_beef, 0, 0, 0, 1));
    vt.push_back(mk(1, 32'h0000_010c, 0, 32'hdead_beef, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(1, 32'h0000_0110, 0, 32'h1234_5678, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < vt.size(); i++) step(vt[i]);

    // flush with one queued and one in flight, redirect accepted same cycle
    step(mk(1, 32'h0000_0200, 0, 0, 0, 0, 1, 0));
    step(mk(1, 32'h0000_0204, 0, 0, 0, 0, 1, 0));
    step(mk(1, 32'hbfc0_0380, 0, 0, 1, 1, 1, 1));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 1));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));

    // flush with FIFO full and no redirect fetch
    step(mk(1, 32'h0000_0300, 0, 0, 0, 0, 1, 0));
    step(mk(1, 32'h0000_0304, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 0, 1, 1, 1));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));

    // asynchronous reset with two entries queued
    step(mk(1, 32'h0000_0400, 0, 0, 0, 0, 1, 0));
    step(mk(1, 32'h0000_0404, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_q.delete();
    prev_acc = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(1, 32'h0000_0500, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 1, 0, 1, 1));
    step(mk(0, 0, 0, 0, 1, 0, 1, 0));

    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
